// File: rtl/aibcr3_txdig_seq_if.sv
// TX digital sequencer bundle: bring-up request/config in,
// pad/launch-flop control and status out.
interface aibcr3_txdig_seq_if #(
  parameter int DLY_W = 8
);
  logic             i_tx_req;
  logic             i_ddr_mode;
  logic [DLY_W-1:0] i_dly;
  logic             o_ipadrstb;
  logic             o_irstb;
  logic             o_itx_en;
  logic             o_idataselb;
  logic             o_iddrctrl;
  logic             o_async_data;
  logic             o_tx_ready;
  logic             o_busy;
  logic [2:0]       o_state;

  modport master (
    output i_tx_req, i_ddr_mode, i_dly,
    input  o_ipadrstb, o_irstb, o_itx_en,
    input  o_idataselb, o_iddrctrl, o_async_data,
    input  o_tx_ready, o_busy, o_state
  );

  modport slave (
    input  i_tx_req, i_ddr_mode, i_dly,
    output o_ipadrstb, o_irstb, o_itx_en,
    output o_idataselb, o_iddrctrl, o_async_data,
    output o_tx_ready, o_busy, o_state
  );
endinterface

// File: rtl/aibcr3_txdig_seq.sv
// TX pad bring-up / shutdown sequencer: staged reset release,
// driver enable, clocked-path select and DDR capture.
module aibcr3_txdig_seq #(
  parameter int DLY_W   = 8,
  parameter int MIN_OFF = 4
) (
  input logic               iclk,
  input logic               irst,
  aibcr3_txdig_seq_if.slave bus
);
  // Counter also holds MIN_OFF-1 (up to 254), so never narrower than 8.
  localparam int CW = (DLY_W > 8) ? DLY_W : 8;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PADREL = 3'd1,
    S_FFREL  = 3'd2,
    S_TXEN   = 3'd3,
    S_LIVE   = 3'd4,
    S_DRAIN  = 3'd5
  } state_e;

  logic [2:0]    state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ddr_q, ddr_d;
  logic          pad_q, pad_d;
  logic          rstb_q, rstb_d;
  logic          txen_q, txen_d;
  logic          sel_q, sel_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic [2:0]    st_q;

  logic [CW-1:0] dly_ld;
  logic [CW-1:0] off_ld;
  logic [CW-1:0] cnt_dec;
  logic          cnt_z;
  logic          req;

  assign dly_ld  = CW'(bus.i_dly);
  assign off_ld  = CW'(MIN_OFF - 1);
  assign cnt_z   = (cnt_q == '0);
  assign cnt_dec = cnt_z ? '0 : cnt_q - 1'b1;
  assign req     = bus.i_tx_req;

  always_comb begin
    state_d = S_OFF;
    cnt_d   = cnt_q;
    ddr_d   = 1'b0;
    case (state_q)
      S_OFF: begin
        state_d = S_OFF;
        cnt_d   = cnt_dec;
        if (req && cnt_z) begin
          state_d = S_PADREL;
          cnt_d   = dly_ld;
        end
      end
      S_PADREL: begin
        if (!req) begin
          state_d = S_OFF;
          cnt_d   = off_ld;
        end else if (cnt_z) begin
          state_d = S_FFREL;
          cnt_d   = dly_ld;
        end else begin
          state_d = S_PADREL;
          cnt_d   = cnt_dec;
        end
      end
      S_FFREL: begin
        if (!req) begin
          state_d = S_OFF;
          cnt_d   = off_ld;
        end else if (cnt_z) begin
          state_d = S_TXEN;
          cnt_d   = dly_ld;
        end else begin
          state_d = S_FFREL;
          cnt_d   = cnt_dec;
        end
      end
      S_TXEN: begin
        if (!req) begin
          state_d = S_DRAIN;
          cnt_d   = dly_ld;
        end else if (cnt_z) begin
          state_d = S_LIVE;
          cnt_d   = dly_ld;
          ddr_d   = bus.i_ddr_mode;
        end else begin
          state_d = S_TXEN;
          cnt_d   = cnt_dec;
        end
      end
      S_LIVE: begin
        if (!req) begin
          state_d = S_DRAIN;
          cnt_d   = dly_ld;
        end else begin
          state_d = S_LIVE;
          ddr_d   = ddr_q;
        end
      end
      S_DRAIN: begin
        if (cnt_z) begin
          state_d = S_OFF;
          cnt_d   = off_ld;
        end else begin
          state_d = S_DRAIN;
          cnt_d   = cnt_dec;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = off_ld;
      end
    endcase
  end

  // Output flops are loaded from the next state so they track state_q.
  always_comb begin
    pad_d  = (state_d != S_OFF);
    rstb_d = state_d inside {S_FFREL, S_TXEN, S_LIVE, S_DRAIN};
    txen_d = state_d inside {S_TXEN, S_LIVE, S_DRAIN};
    sel_d  = (state_d == S_LIVE);
    rdy_d  = (state_d == S_LIVE);
    busy_d = state_d inside {S_PADREL, S_FFREL, S_TXEN, S_DRAIN};
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      ddr_q   <= 1'b0;
      pad_q   <= 1'b0;
      rstb_q  <= 1'b0;
      txen_q  <= 1'b0;
      sel_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      st_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ddr_q   <= ddr_d;
      pad_q   <= pad_d;
      rstb_q  <= rstb_d;
      txen_q  <= txen_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      st_q    <= state_d;
    end
  end

  assign bus.o_ipadrstb   = pad_q;
  assign bus.o_irstb      = rstb_q;
  assign bus.o_itx_en     = txen_q;
  assign bus.o_idataselb  = sel_q;
  assign bus.o_iddrctrl   = ddr_q;
  assign bus.o_async_data = 1'b0;
  assign bus.o_tx_ready   = rdy_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_state      = st_q;
endmodule

// File: tb/tb_aibcr3_txdig_seq.sv
// Bench for aibcr3_txdig_seq: vector table, corner sequences
// and randomized traffic against a phase/elapsed-time model.
module tb_aibcr3_txdig_seq;
  localparam int DLY_W   = 8;
  localparam int MIN_OFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aibcr3_txdig_seq_if #(.DLY_W(DLY_W)) bus ();

  aibcr3_txdig_seq #(
    .DLY_W  (DLY_W),
    .MIN_OFF(MIN_OFF)
  ) dut (
    .iclk(clk),
    .irst(rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit mdl_on = 1'b1;

  // Model: phase, cycles elapsed in it, dwell length, OFF wait.
  int ph, el, dwell, need;
  bit mddr;

  typedef struct {
    bit         rst;
    bit         req;
    bit         ddr;
    logic [7:0] dly;
    logic [2:0] st;
    bit         dd;
  } vec_t;

  vec_t tv [17];

  // {state, ipadrstb, irstb, itx_en, idataselb, iddrctrl, async, ready, busy}
  function automatic logic [10:0] expv(int p, bit d);
    logic [7:0] t;
    case (p)
      1:       t = 8'b1000_0001;
      2:       t = 8'b1100_0001;
      3:       t = 8'b1110_0001;
      4:       t = {4'b1111, d, 3'b010};
      5:       t = 8'b1110_0001;
      default: t = 8'b0000_0000;
    endcase
    return {3'(p), t};
  endfunction

  function automatic logic [10:0] outs();
    return {bus.o_state, bus.o_ipadrstb, bus.o_irstb,
            bus.o_itx_en, bus.o_idataselb, bus.o_iddrctrl,
            bus.o_async_data, bus.o_tx_ready, bus.o_busy};
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic go(int p);
    ph    = p;
    el    = 0;
    dwell = int'(bus.i_dly) + 1;
  endtask

  task automatic to_off();
    ph   = 0;
    el   = 0;
    need = MIN_OFF;
  endtask

  task automatic model_step();
    int e;
    bit r;
    e = el + 1;
    r = bus.i_tx_req;
    if (rst) begin
      ph   = 0;
      el   = 0;
      need = 1;
      mddr = 1'b0;
    end else begin
      case (ph)
        0: if (r && e >= need) go(1); else el = e;
        1, 2: begin
          if (!r) to_off();
          else if (e == dwell) go(ph + 1);
          else el = e;
        end
        3: begin
          if (!r) go(5);
          else if (e == dwell) begin
            go(4);
            mddr = bus.i_ddr_mode;
          end else el = e;
        end
        4: begin
          if (!r) begin
            go(5);
            mddr = 1'b0;
          end
        end
        default: begin
          if (e == dwell) to_off();
          else el = e;
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (mdl_on) chk("model", int'(outs()), int'(expv(ph, mddr)));
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.i_tx_req   = 1'b0;
    step();
    rst            = 1'b0;
  endtask

  initial begin
    int n;
    bus.i_tx_req   = 1'b0;
    bus.i_ddr_mode = 1'b0;
    bus.i_dly      = '0;
    ph = 0; el = 0; dwell = 1; need = 1; mddr = 1'b0;

    tv[0]  = '{1, 0, 0, 8'd2, 3'd0, 0};
    tv[1]  = '{0, 1, 0, 8'd2, 3'd1, 0};
    tv[2]  = '{0, 1, 0, 8'd2, 3'd1, 0};
    tv[3]  = '{0, 1, 0, 8'd2, 3'd1, 0};
    tv[4]  = '{0, 1, 0, 8'd2, 3'd2, 0};
    tv[5]  = '{0, 1, 0, 8'd2, 3'd2, 0};
    tv[6]  = '{0, 1, 0, 8'd2, 3'd2, 0};
    tv[7]  = '{0, 1, 1, 8'd2, 3'd3, 0};
    tv[8]  = '{0, 1, 1, 8'd2, 3'd3, 0};
    tv[9]  = '{0, 1, 1, 8'd2, 3'd3, 0};
    tv[10] = '{0, 1, 1, 8'd2, 3'd4, 1};
    tv[11] = '{0, 1, 0, 8'd2, 3'd4, 1};
    tv[12] = '{0, 1, 1, 8'd2, 3'd4, 1};
    tv[13] = '{0, 1, 0, 8'd2, 3'd4, 1};
    tv[14] = '{0, 0, 0, 8'd0, 3'd5, 0};
    tv[15] = '{0, 0, 0, 8'd0, 3'd0, 0};
    tv[16] = '{0, 0, 1, 8'd0, 3'd0, 0};

    for (int i = 0; i < 17; i++) begin
      rst            = tv[i].rst;
      bus.i_tx_req   = tv[i].req;
      bus.i_ddr_mode = tv[i].ddr;
      bus.i_dly      = tv[i].dly;
      step();
      chk($sformatf("vec%0d", i), int'(outs()),
          int'(expv(int'(tv[i].st), tv[i].dd)));
    end

    // Abort in FFREL with one dwell cycle left, then MIN_OFF wait.
    do_reset();
    bus.i_tx_req = 1'b1;
    bus.i_dly    = 8'd2;
    repeat (5) step();
    chk("ffrel_before_abort", int'(bus.o_state), 2);
    bus.i_tx_req = 1'b0;
    step();
    chk("abort_off", int'(outs()), 0);
    bus.i_tx_req = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.o_state == 3'd1) begin
        n = k;
        break;
      end
    end
    chk("min_off_wait", n, MIN_OFF);

    // Reset mid-TXEN dwell, immediate restart.
    do_reset();
    bus.i_tx_req = 1'b1;
    bus.i_dly    = 8'd5;
    repeat (13) step();
    chk("txen_before_rst", int'(bus.o_state), 3);
    rst = 1'b1;
    step();
    chk("rst_outputs", int'(outs()), 0);
    rst = 1'b0;
    step();
    chk("restart_after_rst", int'(bus.o_state), 1);

    // Longest dwell.
    do_reset();
    bus.i_tx_req = 1'b1;
    bus.i_dly    = 8'd255;
    step();
    n = 0;
    while (bus.o_state == 3'd1 && n < 400) begin
      n++;
      step();
    end
    chk("dwell_255", n, 256);

    // Shortest bring-up.
    do_reset();
    bus.i_tx_req = 1'b1;
    bus.i_dly    = 8'd0;
    n = 0;
    while (!bus.o_tx_ready && n < 20) begin
      n++;
      step();
    end
    chk("min_bringup", n, 4);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) bus.i_tx_req = ~bus.i_tx_req;
      bus.i_ddr_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        bus.i_dly = 8'($urandom_range(0, 12));
      else
        bus.i_dly = 8'($urandom_range(0, 3));
      step();
    end

    // Unused state code recovers to OFF.
    rst          = 1'b0;
    bus.i_tx_req = 1'b0;
    mdl_on       = 1'b0;
    @(negedge clk);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    step();
    chk("illegal_state", int'(outs()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aibcr3_txdig_seq.md
AIBCR3_TXDIG_SEQ -- requirements
Module: aibcr3_txdig_seq

Interface
REQ-001 Parameter DLY_W, default 8: width of the programmable dwell-delay input and of the dwell counter.
REQ-002 Parameter MIN_OFF, default 4: minimum number of cycles spent in OFF before a new bring-up may start; legal range 1..255.
REQ-003 Port iclk, input, 1: single clock, identical to the TX launch clock; all state updates on its rising edge.
REQ-004 Port irst, input, 1: reset, synchronous, active-high.
REQ-005 Port i_tx_req, input, 1: level request; 1 = bring the TX pad live, 0 = shut it down.
REQ-006 Port i_ddr_mode, input, 1: 1 = DDR launch, 0 = SDR launch.
REQ-007 Port i_dly, input, DLY_W: dwell delay in cycles, sampled at each counter load.
REQ-008 Port o_ipadrstb, output, 1: pad reset release (active-low reset) to the TX datapath.
REQ-009 Port o_irstb, output, 1: launch-flop reset release (active-low reset).
REQ-010 Port o_itx_en, output, 1: TX driver enable.
REQ-011 Port o_idataselb, output, 1: path select; 1 = clocked DDR/SDR path, 0 = async path.
REQ-012 Port o_iddrctrl, output, 1: DDR control to the datapath.
REQ-013 Port o_async_data, output, 1: async path data; always 0 in this block.
REQ-014 Port o_tx_ready, output, 1: 1 only in LIVE.
REQ-015 Port o_busy, output, 1: 1 in every state except OFF and LIVE.
REQ-016 Port o_state, output, 3: state encoding, with OFF=0, PADREL=1, FFREL=2, TXEN=3, LIVE=4, DRAIN=5; codes 6 and 7 are unused.

Function
REQ-017 All outputs SHALL be registered, decoded from the registered state plus the registered o_iddrctrl flop, with no combinational path from any input to any output.
REQ-018 OFF SHALL drive all outputs 0, with o_state=0.
REQ-019 OFF->PADREL SHALL occur when i_tx_req=1 and the OFF counter is 0; the counter SHALL load i_dly on this transition.
REQ-020 PADREL SHALL drive o_ipadrstb=1, with all other enables 0.
REQ-021 FFREL SHALL add o_irstb=1.
REQ-022 TXEN SHALL add o_itx_en=1, with the async path still selected (o_idataselb=0, o_async_data=0).
REQ-023 Each dwell state (PADREL, FFREL, TXEN, DRAIN) SHALL last exactly i_dly+1 cycles, with i_dly taken at load.
REQ-024 Each dwell state SHALL decrement the counter each cycle and advance when the counter is 0, reloading i_dly on advance.
REQ-025 The forward sequence SHALL be PADREL->FFREL->TXEN->LIVE.
REQ-026 The i_ddr_mode value SHALL be captured into o_iddrctrl on the TXEN->LIVE edge and held until exit from LIVE; changes to i_ddr_mode during LIVE SHALL be ignored.
REQ-027 LIVE SHALL drive o_ipadrstb=1, o_irstb=1, o_itx_en=1, o_idataselb=1 and o_tx_ready=1.
REQ-028 LIVE->DRAIN SHALL occur on i_tx_req=0, loading i_dly.
REQ-029 DRAIN SHALL drive o_idataselb=0 (async path, data 0) while o_ipadrstb=1, o_irstb=1 and o_itx_en=1; o_iddrctrl SHALL be cleared on DRAIN entry.
REQ-030 DRAIN->OFF SHALL occur when the counter is 0; the counter SHALL load MIN_OFF-1 on this transition.
REQ-031 An abort with i_tx_req=0 in PADREL or FFREL SHALL go to OFF on the next edge, loading MIN_OFF-1.
REQ-032 An abort with i_tx_req=0 in TXEN SHALL go to DRAIN, loading i_dly.
REQ-033 i_tx_req=1 during DRAIN SHALL have no effect until OFF has been reached and MIN_OFF has elapsed.
REQ-034 In OFF the counter SHALL decrement to 0 and saturate there; i_tx_req=1 SHALL not start a new bring-up while the counter is nonzero.
REQ-035 An i_dly value of all-ones SHALL give a dwell of 2^DLY_W cycles, with no wrap-around error.
REQ-036 Unused state codes SHALL return to OFF on the next edge.

Reset
REQ-037 irst=1 SHALL force OFF with counter=0, all outputs 0 and o_state=0 at the next rising edge, from any state including mid-dwell.
REQ-038 irst SHALL take priority over i_tx_req.
REQ-039 A bring-up SHALL be allowed on the first edge after irst is released; there is no MIN_OFF wait after reset.

Verification
REQ-040 Reset, then i_tx_req=1 and i_dly=2 held. Required: PADREL, FFREL and TXEN each for 3 cycles; o_tx_ready=1 on cycle 10 after the request; enables rise in order ipadrstb, irstb, itx_en, idataselb.
REQ-041 In LIVE with i_ddr_mode=1 at entry, toggle i_ddr_mode. Required: o_iddrctrl stays 1. Then drop i_tx_req with i_dly=0. Required: DRAIN for 1 cycle with idataselb=0 and itx_en=1, then OFF with all outputs 0.
REQ-042 Drop i_tx_req in FFREL at counter=1. Required: OFF next cycle. Reassert i_tx_req immediately with MIN_OFF=4. Required: PADREL entered exactly 4 cycles after OFF entry.
REQ-043 Assert irst during TXEN with counter=5. Required: next cycle all outputs 0, o_state=0; bring-up restarts on the first cycle after irst falls when i_tx_req=1.
REQ-044 i_dly=255 with DLY_W=8. Required: PADREL dwell of exactly 256 cycles. i_dly=0 in every state. Required: minimum total bring-up of 4 cycles.
REQ-045 Force o_state code 6 via a backdoor. Required: OFF on the next edge.
